// File: rtl/cond_mon_pkg.sv
// Shared types and helpers for the conditional-property monitor: channel modes,
// channel FSM states and the saturating adder used by the failure counter.
package cond_mon_pkg;

  typedef enum logic [1:0] {
    IMM = 2'd0,
    HS  = 2'd1,
    WIN = 2'd2,
    SEQ = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    S1   = 2'd2,
    S2   = 2'd3
  } chan_state_e;

  // Adds inc to count and clamps the result at max_val instead of wrapping.
  function automatic int unsigned sat_add(input int unsigned count,
                                          input int unsigned inc,
                                          input int unsigned max_val);
    longint unsigned sum;
    sum = 64'(count) + 64'(inc);
    return (sum > 64'(max_val)) ? max_val : 32'(sum);
  endfunction

endpackage

// File: rtl/cond_mon_chan.sv
// One checker channel: IMM/HS evaluated in IDLE, WIN/SEQ tracked by a small FSM.
// Concurrent assertions/covers are emitted only when COND_PROP_MON_SVA_EN is defined.
module cond_mon_chan
  import cond_mon_pkg::*;
#(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 3,
  parameter int DLY_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       req,
  input  logic       ack,
  input  logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       fail,
  output logic       fail_d
);

  localparam logic [DLY_W:0] MIN_K = (DLY_W + 1)'(MIN_DLY);
  localparam logic [DLY_W:0] MAX_K = (DLY_W + 1)'(MAX_DLY);

  mode_e            mode_in;
  chan_state_e      state, state_d;
  logic [DLY_W-1:0] cnt, cnt_d;
  logic [DLY_W:0]   k;

  assign mode_in = mode_e'(mode);
  // cnt holds the offset of the previous cycle; k is the ack offset seen now.
  assign k       = {1'b0, cnt} + (DLY_W + 1)'(1);
  assign busy    = (state != IDLE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fail_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (mode_in)
            IMM: fail_d = req & ~ack;
            HS:  fail_d = valid & ~ready;
            WIN: if (req) begin
              state_d = WAIT;
              cnt_d   = '0;
            end
            SEQ: if (req) state_d = S1;
            default: ;
          endcase
        end
        WAIT: begin
          cnt_d = cnt + DLY_W'(1);
          if (ack && (k >= MIN_K)) begin
            state_d = IDLE;
          end else if (k >= MAX_K) begin
            state_d = IDLE;
            fail_d  = 1'b1;
          end
        end
        S1: begin
          if (valid) begin
            state_d = S2;
          end else begin
            state_d = IDLE;
            fail_d  = 1'b1;
          end
        end
        S2: begin
          state_d = IDLE;
          fail_d  = ~ready;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and fail pulse register; the delay counter is datapath and not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fail  <= 1'b0;
    end else begin
      state <= state_d;
      fail  <= fail_d;
    end
    cnt <= cnt_d;
  end

`ifdef COND_PROP_MON_SVA_EN
  mode_e mode_q;
  logic  trig;

  assign trig = (state == IDLE) && req && ((mode_in == WIN) || (mode_in == SEQ));

  always_ff @(posedge clk) begin
    if (trig) mode_q <= mode_in;
  end

  property p_multi_cycle;
    @(posedge clk) disable iff (rst || !en)
      trig |=> if (mode_q == WIN) (##[MIN_DLY-1:MAX_DLY-1] ack)
               else (valid ##1 ready);
  endproperty

  a_multi_cycle: assert property (p_multi_cycle);
  a_imm: assert property (@(posedge clk) disable iff (rst || !en)
    ((state == IDLE) && (mode_in == IMM) && req) |-> ack);
  a_hs: assert property (@(posedge clk) disable iff (rst || !en)
    ((state == IDLE) && (mode_in == HS) && valid) |-> ready);
  a_fail_agree: assert property (@(posedge clk) disable iff (rst)
    fail_d |=> fail);

  c_imm_pass: cover property (@(posedge clk) disable iff (rst || !en)
    (state == IDLE) && (mode_in == IMM) && req && ack);
  c_hs_pass: cover property (@(posedge clk) disable iff (rst || !en)
    (state == IDLE) && (mode_in == HS) && valid && ready);
  c_win_pass: cover property (@(posedge clk) disable iff (rst || !en)
    (state == WAIT) && ack && (k >= MIN_K));
  c_seq_pass: cover property (@(posedge clk) disable iff (rst || !en)
    (state == S2) && ready);
`endif

endmodule

// File: rtl/cond_prop_monitor.sv
// Multi-channel conditional-property monitor: per-channel checkers plus sticky
// flags and a saturating failure count. Optional SVA via COND_PROP_MON_SVA_EN.
module cond_prop_monitor
  import cond_mon_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 3,
  parameter int DLY_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   ack,
  input  logic [NCH-1:0]   valid,
  input  logic [NCH-1:0]   ready,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   fail,
  output logic [NCH-1:0]   fail_sticky,
  output logic [CNT_W-1:0] fail_count
);

  localparam int unsigned CNT_MAX = 32'({CNT_W{1'b1}});

  logic [NCH-1:0] fail_d;
  int unsigned    nfail;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cond_mon_chan #(
      .MIN_DLY (MIN_DLY),
      .MAX_DLY (MAX_DLY),
      .DLY_W   (DLY_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode[2*i +: 2]),
      .req    (req[i]),
      .ack    (ack[i]),
      .valid  (valid[i]),
      .ready  (ready[i]),
      .busy   (busy[i]),
      .fail   (fail[i]),
      .fail_d (fail_d[i])
    );
  end

  always_comb begin
    nfail = 0;
    for (int i = 0; i < NCH; i++) nfail += {31'd0, fail_d[i]};
  end

  // Sticky flags and count follow the pre-register fail so they update with the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_sticky <= '0;
      fail_count  <= '0;
    end else begin
      fail_sticky <= fail_sticky | fail_d;
      fail_count  <= CNT_W'(sat_add(32'(fail_count), nfail, CNT_MAX));
    end
  end

endmodule
